vpopc_ctrl: RTL and testbench

- Sequencer that runs one vector mask population-count (vcpop.m) command on the shared vPopc pipeline.
- Takes a command (vl, sew, mask base address) and reads mask beats from the mask register file.
- Drives vPopc's in_m0 / in_valid / in_start / in_end, with tail elements beyond vl zeroed.
- Captures vPopc's result and returns it on a valid/ready response port. Sits between the vector issue stage and the vPopc instance.

---
 rtl/vpopc_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vpopc_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpopc_ctrl.sv
// Sequencer for one vcpop.m command: streams mask beats from the mask register
// file into the shared vPopc pipeline and returns the population count.
module vpopc_ctrl #(
    parameter int REQ_DATA_WIDTH  = 8,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int SEW_WIDTH       = 2,
    parameter int VL_WIDTH        = 11,
    parameter int ADDR_WIDTH      = 8,
    parameter int POPC_LAT        = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [VL_WIDTH-1:0]        cmd_vl,
    input  logic [SEW_WIDTH-1:0]       cmd_sew,
    input  logic [ADDR_WIDTH-1:0]      cmd_base,
    output logic                       rd_req,
    output logic [ADDR_WIDTH-1:0]      rd_addr,
    input  logic [REQ_DATA_WIDTH-1:0]  rd_data,
    output logic [REQ_DATA_WIDTH-1:0]  popc_m0,
    output logic                       popc_valid,
    output logic [SEW_WIDTH-1:0]       popc_sew,
    output logic                       popc_start,
    output logic                       popc_end,
    input  logic [RESP_DATA_WIDTH-1:0] popc_out_vec,
    input  logic                       popc_out_valid,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [RESP_DATA_WIDTH-1:0] resp_data,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid never depends on ready, and resp_data is held while
    // resp_valid is high and resp_ready is low.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int LOG_RDW = $clog2(REQ_DATA_WIDTH);
    localparam int LIMW    = LOG_RDW + 1;
    localparam int NW      = VL_WIDTH + 1;

    if (POPC_LAT < 1 || REQ_DATA_WIDTH < 8 || (1 << LOG_RDW) != REQ_DATA_WIDTH) begin : g_param_check
        $error("vpopc_ctrl: unsupported parameter combination");
    end

    state_t                     state;
    logic [SEW_WIDTH-1:0]       sew_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [NW-1:0]              n_beats;
    logic [LIMW-1:0]            tail_limit;
    logic [VL_WIDTH-1:0]        beat_cnt;
    logic                       tag_valid;
    logic                       tag_first;
    logic                       tag_last;
    logic [LIMW-1:0]            tag_limit;
    logic [RESP_DATA_WIDTH-1:0] resp_q;

    logic [NW-1:0]              cmd_epb;
    logic [NW-1:0]              cmd_n;
    logic [LIMW-1:0]            cmd_epb_lo;
    logic [LIMW-1:0]            cmd_rem;
    logic [LIMW-1:0]            cmd_limit;
    logic                       is_last;
    logic [REQ_DATA_WIDTH-1:0]  tail_mask;

    // Beat count and last-beat bit limit are derived once, at command capture.
    always_comb begin
        cmd_epb    = NW'(REQ_DATA_WIDTH) >> cmd_sew;
        cmd_n      = ({1'b0, cmd_vl} + cmd_epb - NW'(1)) >> (LOG_RDW - int'(cmd_sew));
        cmd_epb_lo = LIMW'(REQ_DATA_WIDTH) >> cmd_sew;
        cmd_rem    = ((cmd_vl[LIMW-1:0] - LIMW'(1)) & (cmd_epb_lo - LIMW'(1))) + LIMW'(1);
        cmd_limit  = cmd_rem << cmd_sew;
    end

    assign is_last = ({1'b0, beat_cnt} == (n_beats - NW'(1)));

    always_comb begin
        tail_mask = '0;
        for (int p = 0; p < REQ_DATA_WIDTH; p++) begin
            tail_mask[p] = (LIMW'(p) < tag_limit);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sew_q      <= '0;
            addr_q     <= '0;
            n_beats    <= '0;
            tail_limit <= '0;
            beat_cnt   <= '0;
            tag_valid  <= 1'b0;
            tag_first  <= 1'b0;
            tag_last   <= 1'b0;
            tag_limit  <= '0;
            resp_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        sew_q      <= cmd_sew;
                        addr_q     <= cmd_base;
                        n_beats    <= cmd_n;
                        tail_limit <= cmd_limit;
                        beat_cnt   <= '0;
                        resp_q     <= '0;
                        state      <= (cmd_vl == '0) ? RESP : ISSUE;
                    end
                end
                ISSUE: begin
                    beat_cnt <= beat_cnt + VL_WIDTH'(1);
                    addr_q   <= addr_q + ADDR_WIDTH'(1);
                    if (is_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (popc_out_valid) begin
                        resp_q <= popc_out_vec;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_q <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Tag travels one cycle behind the read so it lines up with rd_data.
            tag_valid <= (state == ISSUE);
            tag_first <= (state == ISSUE) && (beat_cnt == '0);
            tag_last  <= (state == ISSUE) && is_last;
            tag_limit <= ((state == ISSUE) && is_last) ? tail_limit : LIMW'(REQ_DATA_WIDTH);
        end
    end

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign dbg_state  = state;
    assign rd_req     = (state == ISSUE);
    assign rd_addr    = rd_req ? addr_q : '0;
    assign popc_valid = tag_valid;
    assign popc_m0    = tag_valid ? (rd_data & tail_mask) : '0;
    assign popc_start = tag_valid & tag_first;
    assign popc_end   = tag_valid & tag_last;
    assign popc_sew   = sew_q;
    assign resp_valid = (state == RESP);
    assign resp_data  = resp_q;

endmodule

// File: tb/tb_vpopc_ctrl.sv
// Scoreboard bench for vpopc_ctrl: behavioural mask-RF and vPopc stand-ins,
// element-level reference model, decoupled response/beat monitors.
module tb_vpopc_ctrl;
    localparam int POPC_LAT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_vl;
    logic [1:0]  cmd_sew;
    logic [7:0]  cmd_base;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic [7:0]  popc_m0;
    logic        popc_valid;
    logic [1:0]  popc_sew;
    logic        popc_start;
    logic        popc_end;
    logic [63:0] popc_out_vec;
    logic        popc_out_valid;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        busy;
    logic [1:0]  dbg_state;

    vpopc_ctrl #(
        .REQ_DATA_WIDTH(8), .RESP_DATA_WIDTH(64), .SEW_WIDTH(2),
        .VL_WIDTH(11), .ADDR_WIDTH(8), .POPC_LAT(POPC_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vl(cmd_vl),
        .cmd_sew(cmd_sew), .cmd_base(cmd_base),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .popc_m0(popc_m0), .popc_valid(popc_valid), .popc_sew(popc_sew),
        .popc_start(popc_start), .popc_end(popc_end),
        .popc_out_vec(popc_out_vec), .popc_out_valid(popc_out_valid),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- environment models ----------------
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (rd_req) rd_data <= mem[rd_addr];
        else        rd_data <= 8'($urandom);
    end

    logic [POPC_LAT-1:0] pv = '0;
    logic [63:0]         pd [POPC_LAT];
    logic [63:0]         acc = 64'd0;
    logic                stray_v = 1'b0;
    logic [63:0]         stray_d = 64'd0;
    always @(posedge clk) begin
        logic [63:0] nxt;
        int c;
        nxt = acc;
        if (popc_valid) begin
            c = 0;
            for (int p = 0; p < 8; p++)
                if ((p % (1 << popc_sew)) == 0 && popc_m0[p]) c++;
            nxt = (popc_start ? 64'd0 : acc) + 64'(c);
            acc <= nxt;
        end
        for (int i = POPC_LAT - 1; i > 0; i--) pd[i] <= pd[i-1];
        pv    <= {pv[POPC_LAT-2:0], popc_valid & popc_end};
        pd[0] <= nxt;
    end
    assign popc_out_valid = pv[POPC_LAT-1] | stray_v;
    assign popc_out_vec   = pv[POPC_LAT-1] ? pd[POPC_LAT-1] : stray_d;

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];
    int          exp_t_q[$];
    int          exp_d_q[$];
    logic [7:0]  exp_addr_q[$];
    logic [11:0] exp_beat_q[$];
    int          total = 0;
    int          passed = 0;
    int          hs_cyc = -10;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rd_req"}, 64'(rd_req), 64'd0);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_popc_valid"}, 64'(popc_valid), 64'd0);
        check({tag, "_popc_m0"}, 64'(popc_m0), 64'd0);
        check({tag, "_popc_flags"}, 64'({popc_start, popc_end, popc_sew}), 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_data"}, resp_data, 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // ---------------- driver ----------------
    task automatic run_cmd(input int vl, input int sew, input int base,
                           input int ndir, input logic [31:0] dir, input int delay);
        int epb, n, cnt, guard;
        logic [7:0] a, m;
        logic b2b;
        epb = 8 >> sew;
        n = (vl + epb - 1) / epb;
        @(negedge clk);
        guard = 0;
        while (!(cmd_ready || resp_valid) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) begin fail_now("cmd_slot_timeout"); return; end
        b2b = resp_valid && !cmd_ready;
        for (int b = 0; b < n; b++)
            mem[8'(base + b)] = (b < ndir) ? dir[8*b +: 8] : 8'($urandom);
        cmd_valid = 1'b1;
        cmd_vl = 11'(vl);
        cmd_sew = 2'(sew);
        cmd_base = 8'(base);
        guard = 0;
        while (!cmd_ready && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin fail_now("cmd_accept_timeout"); cmd_valid = 1'b0; return; end
        if (b2b) check("b2b_accept_cycle", 64'(cyc), 64'(hs_cyc + 1));
        // Reference: element i lives in beat i/epb at bit (i%epb)<<sew.
        cnt = 0;
        for (int i = 0; i < vl; i++)
            if (mem[8'(base + i / epb)][(i % epb) << sew]) cnt++;
        for (int b = 0; b < n; b++) begin
            a = 8'(base + b);
            m = 8'h00;
            for (int p = 0; p < 8; p++)
                if (b * epb + (p >> sew) < vl) m[p] = mem[a][p];
            exp_addr_q.push_back(a);
            exp_beat_q.push_back({2'(sew), (b == 0), (b == n - 1), m});
        end
        exp_q.push_back(64'(cnt));
        exp_t_q.push_back((vl == 0) ? cyc + 1 : cyc + n + 2 + POPC_LAT);
        exp_d_q.push_back(delay);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(exp_q.size() == 0 && cmd_ready && !resp_ready) && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 30000) fail_now("idle_timeout");
    endtask

    // ---------------- beat / address monitor ----------------
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (rd_req) begin
                if (exp_addr_q.size() == 0) fail_now("rd_req_unexpected");
                else check("rd_addr", 64'(rd_addr), 64'(exp_addr_q.pop_front()));
            end
            if (popc_valid) begin
                if (exp_beat_q.size() == 0) fail_now("popc_beat_unexpected");
                else check("popc_beat{sew,start,end,m0}",
                           64'({popc_sew, popc_start, popc_end, popc_m0}),
                           64'(exp_beat_q.pop_front()));
            end
        end
    end

    // ---------------- response monitor ----------------
    int          waiting = 0;
    int          wcnt = 0;
    int          cur_delay = 0;
    logic [63:0] held = 64'd0;
    initial begin
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                resp_ready = 1'b0;
                waiting = 0;
            end else if (resp_ready) begin
                resp_ready = 1'b0;
                check("resp_valid_cleared", 64'(resp_valid), 64'd0);
            end else if (resp_valid) begin
                if (waiting == 0) begin
                    waiting = 1;
                    wcnt = 0;
                    held = resp_data;
                    if (exp_t_q.size() == 0) begin
                        fail_now("resp_unexpected");
                        cur_delay = 0;
                    end else begin
                        check("resp_latency_cycle", 64'(cyc), 64'(exp_t_q.pop_front()));
                        cur_delay = exp_d_q.pop_front();
                    end
                end else begin
                    check("resp_data_stable", resp_data, held);
                    check("cmd_ready_while_resp", 64'(cmd_ready), 64'd0);
                    check("busy_while_resp", 64'(busy), 64'd1);
                end
                if (wcnt >= cur_delay) begin
                    if (exp_q.size() == 0) fail_now("resp_data_unexpected");
                    else check("resp_data", resp_data, exp_q.pop_front());
                    resp_ready = 1'b1;
                    hs_cyc = cyc;
                    waiting = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_vl = '0;
        cmd_sew = '0;
        cmd_base = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #2 rst = 1'b1;

        run_cmd(16, 0, 'h10, 2, 32'h0000_0FFF, 0);
        run_cmd(5, 1, 'h20, 2, 32'h0000_FFFF, 0);
        run_cmd(3, 3, 'h30, 3, 32'h0001_FE01, 0);
        run_cmd(0, $urandom_range(0, 3), $urandom_range(0, 255), 0, 32'h0, 0);
        run_cmd(9, 0, 'h40, 0, 32'h0, 5);
        run_cmd(12, 1, 'h50, 0, 32'h0, 0);
        run_cmd(16, 0, 'hFF, 0, 32'h0, 1);
        run_cmd(1, 2, 'h80, 1, 32'h0000_00FF, 0);
        wait_idle();

        // Reset during ISSUE of a 4-beat command.
        run_cmd(32, 0, 'h60, 0, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
        exp_t_q.delete();
        exp_d_q.delete();
        exp_addr_q.delete();
        exp_beat_q.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        stray_d = 64'h55;
        stray_v = 1'b1;
        @(negedge clk);
        stray_v = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_ignored_cmd_ready", 64'(cmd_ready), 64'd1);
        check("stray_ignored_resp_valid", 64'(resp_valid), 64'd0);
        run_cmd(8, 0, 'h70, 1, 32'h0000_00AA, 0);

        for (int t = 0; t < 30; t++) begin
            int vl;
            vl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom_range(1, 80);
            run_cmd(vl, $urandom_range(0, 3), $urandom_range(0, 255), 0, 32'h0,
                    $urandom_range(0, 3));
        end
        run_cmd(2047, 3, $urandom_range(0, 255), 0, 32'h0, 0);
        run_cmd(2047, 0, $urandom_range(0, 255), 0, 32'h0, 2);
        wait_idle();

        check("addr_queue_drained", 64'(exp_addr_q.size()), 64'd0);
        check("beat_queue_drained", 64'(exp_beat_q.size()), 64'd0);
        check("resp_queue_drained", 64'(exp_t_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
